// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and access-check helper for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

    // Misaligned half/word, undefined funct3, or unsigned store.
    function automatic logic lsu_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]) ||
               (f3[1:0] == 2'b01 && off[0]) || (f3 == F3_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte/half lane extract-and-extend for loads and lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ld,
    output logic [31:0] st
);

    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sh = {off, 3'b000};
        b  = 8'(word >> sh);
        h  = off[1] ? word[31:16] : word[15:0];
        ld = funct3 == F3_B  ? {{24{b[7]}}, b} :
             funct3 == F3_BU ? {24'h0, b} :
             funct3 == F3_H  ? {{16{h[15]}}, h} :
             funct3 == F3_HU ? {16'h0, h} : word;
        st = funct3 == F3_B ? (word & ~(32'hFF << sh)) | (32'(wdata[7:0]) << sh) :
             funct3 == F3_H ? (off[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]}) :
             wdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I load/store initiator for a word-addressed data memory,
// with read-modify-write sub-word stores and misaligned/illegal access rejection.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    lsu_state_t  state, next;
    logic        rdy_q, we_q, err_q, acc, req_err, unused_addr;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] ld, st;

    assign acc         = req_valid && req_ready;
    assign req_err     = lsu_err(req_we, req_funct3, req_addr[1:0]);
    assign unused_addr = ^req_addr[31:DM_ADDRESS+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !acc ? IDLE : req_err ? RESP : (req_we && req_funct3 == F3_W) ? WRITE : READ;
            READ:    next = we_q ? WRITE : RESP;
            WRITE:   next = RESP;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = rdy_q;
        mem_read   = state == READ;
        mem_write  = state == WRITE;
        resp_valid = state == RESP;
        resp_err   = state == RESP && err_q;
    end

    lsu_align u_align (
        .off    (off_q),
        .funct3 (f3_q),
        .word   (mem_rd),
        .wdata  (mem_wd),
        .ld     (ld),
        .st     (st)
    );

    // mem_wd holds the raw store data until READ replaces it with the merged word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            off_q      <= '0;
            f3_q       <= '0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            resp_rdata <= '0;
        end else begin
            rdy_q <= next == IDLE;
            if (acc) begin
                mem_addr <= req_addr[DM_ADDRESS+1:2];
                mem_wd   <= req_wdata;
                off_q    <= req_addr[1:0];
                f3_q     <= req_funct3;
                we_q     <= req_we;
                err_q    <= req_err;
            end
            if (state == READ && we_q)
                mem_wd <= st;
            if (state == READ && !we_q)
                resp_rdata <= ld;
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle initiator that sits between the core's execute stage and the word-addressed data memory. It turns byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into data-memory read/write cycles. It performs read-modify-write for sub-word stores and extracts and extends sub-word loads. It reports misaligned or illegal accesses without touching memory.

## Interface

Parameters:
- DM_ADDRESS, 9: data-memory word-address width.
- DATA_W, 32: data width; the unit is defined only for 32.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: core presents an access.
- req_ready, out, 1: unit can accept; high only in IDLE.
- req_we, in, 1: 1 = store, 0 = load.
- req_funct3, in, 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr, in, 32: byte address from the ALU.
- req_wdata, in, DATA_W: store data, LSB-aligned.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_err, out, 1: completion was misaligned or illegal; valid with resp_valid.
- resp_rdata, out, DATA_W: extended load result; holds its value until the next successful load.
- mem_read, out, 1: to data memory MemRead.
- mem_write, out, 1: to data memory MemWrite.
- mem_addr, out, DM_ADDRESS: word address, equal to req_addr[DM_ADDRESS+1:2]. Upper address bits are ignored.
- mem_wd, out, DATA_W: write data.
- mem_rd, in, DATA_W: read data. It is combinational from the memory and valid in the same cycle mem_read and mem_addr are stable.

## Operation

- States: IDLE, READ, WRITE, RESP.
- Acceptance:
  - A request is accepted on a rising edge with req_valid and req_ready both high.
  - The unit latches addr, funct3, we and wdata at acceptance. Request inputs are ignored afterwards.
- Error check, made at acceptance:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠00 is misaligned.
  - funct3 011, 110 or 111 is illegal.
  - A store with funct3 100 or 101 is illegal.
  - On any error: IDLE→RESP. No memory cycle occurs.
- Load path:
  - IDLE→READ→RESP.
  - In READ, mem_read=1 and mem_rd is captured at the end of the cycle.
  - The selected byte or half is chosen by addr[1:0], then sign-extended (B/H) or zero-extended (BU/HU) into resp_rdata.
- Word store path:
  - IDLE→WRITE→RESP.
  - In WRITE, mem_write=1 and mem_wd=wdata.
- Sub-word store path:
  - IDLE→READ→WRITE→RESP.
  - READ captures the old word.
  - WRITE drives the old word with the target byte or half replaced by wdata[7:0] or wdata[15:0] at the lane given by addr[1:0].
- RESP:
  - resp_valid=1 for exactly one cycle, then the unit returns to IDLE.
  - resp_err is 1 only when the access was rejected.
  - A failed load leaves resp_rdata unchanged.
- Register rules:
  - mem_read and mem_write are decoded from the state register. They are never high in the same cycle.
  - mem_addr and mem_wd are register-driven and are stable for the whole cycle in which a strobe is high.

## Timing

- Reset: all outputs are 0 and the state is IDLE.
  - req_ready rises in the first cycle after rst_n deasserts.
  - Reset asserted mid-operation drops mem_write and mem_read immediately. No response is issued and the pending access is abandoned.
- Latency, with acceptance edge = cycle N:
  - Load: resp_valid in cycle N+2.
  - Word store: memory written at the end of N+1; resp_valid in N+2.
  - Sub-word store: memory written at the end of N+2; resp_valid in N+3.
  - Error: resp_valid and resp_err in N+1.
- req_ready is low from N+1 until resp_valid is seen. The next request can be accepted on the edge ending the cycle after RESP (back in IDLE). There is no back-to-back overlap.
- A store to a word followed by a load of the same word returns the new data.

## Structure

- Package lsu_pkg holds:
  - the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum typedef lsu_state_t.
- Sub-module lsu_align (combinational) holds:
  - load extract/extend: addr[1:0], funct3, word → result;
  - store merge: addr[1:0], funct3, old word, wdata → new word.
- The FSM and registers stay in load_store_unit.

## Test plan

- Reset mid-load: rst_n low during READ → mem_read=0 immediately; no resp_valid; req_ready=1 one cycle after release.
- SW addr 0x10, data 0xDEADBEEF; then LW 0x10 → word 4 written at N+1; load resp_rdata=0xDEADBEEF, resp_valid at N+2.
- SB 0x13, data 0x80 over word 0x11223344; then LB 0x13 and LBU 0x13:
  - word 4 becomes 0x80223344;
  - LB returns 0xFFFFFF80;
  - LBU returns 0x00000080;
  - the store asserts mem_read in N+1 and mem_write in N+2.
- SH 0x16, data 0x1234, then LH 0x16 → upper half replaced, 0x00001234 returned; LHU 0x16 of 0xF00D gives 0x0000F00D.
- LW 0x12, SH 0x11, funct3 111 → resp_err=1 at N+1; mem_read/mem_write never high; memory and resp_rdata unchanged.
